// File: rtl/snd_sched_pkg.sv
// Shared types and default timing constants for the sound-command scheduler.
package snd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_FULL,
    WAIT_ACK
  } sched_state_t;

  typedef logic [7:0] snd_byte_t;

  localparam int STB_CYC_DEF = 4;
  localparam int TMO_CYC_DEF = 65535;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, even when full.
module snd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk100) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/snd_cmd_sched.sv
// Round-robin sound-command scheduler draining a FIFO into the 68k-to-6502 mailbox.
// Optional counters stat_sent/stat_drop/stat_req1 are built when SND_SCHED_STATS_EN is defined.
module snd_cmd_sched
  import snd_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int STB_CYC = STB_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  snd_byte_t                req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  snd_byte_t                req1_data,
  output logic                     req1_ready,
  output snd_byte_t                mb_data,
  output logic                     mb_wr_b,
  input  logic                     mb_full,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout,
  input  logic                     clr_timeout
`ifdef SND_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_sent,
  output logic [7:0]               stat_drop,
  output logic [15:0]              stat_req1
`endif
);

  localparam int TMR_MAX = (TMO_CYC > STB_CYC) ? TMO_CYC : STB_CYC;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int STB_M1  = STB_CYC - 1;
  localparam int TMO_M1  = TMO_CYC - 1;
  localparam logic [TW-1:0] STB_LAST = STB_M1[TW-1:0];
  localparam logic [TW-1:0] TMO_LAST = TMO_M1[TW-1:0];

  sched_state_t  state, state_nx;
  logic [TW-1:0] tmr;
  logic          tmo_hit;
  logic          pop;
  logic          push;
  logic          space;
  logic          grant0, grant1;
  logic          fifo_empty, fifo_full;
  logic          rr_last;  // set: req0 won the last grant, so req1 wins the next tie
  snd_byte_t     push_data, head;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = rr_last;
      grant0 = !rr_last;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign space      = !fifo_full || pop;
  assign req0_ready = grant0 && space && !rst;
  assign req1_ready = grant1 && space && !rst;
  assign push       = req0_ready || req1_ready;
  assign push_data  = req1_ready ? req1_data : req0_data;
  assign busy       = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk100) begin
    if (rst)             rr_last <= 1'b1;
    else if (req1_ready) rr_last <= 1'b0;
    else if (req0_ready) rr_last <= 1'b1;
  end

  snd_cmd_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk100 (clk100),
    .rst    (rst),
    .push   (push),
    .wdata  (push_data),
    .pop    (pop),
    .rdata  (head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP:  state_nx = STROBE;
      STROBE: if (tmr == STB_LAST) state_nx = WAIT_FULL;
      WAIT_FULL: begin
        // A flag still high from a stale write is taken as this byte's write.
        if (mb_full) state_nx = WAIT_ACK;
        else if (tmr == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_ACK: begin
        if (!mb_full) state_nx = IDLE;
        else if (tmr == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      mb_data <= '0;
      mb_wr_b <= 1'b1;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      tmr     <= (state_nx != state) ? '0 : tmr + 1'b1;
      mb_wr_b <= (state_nx != STROBE);
      if (pop) mb_data <= head;
      if (tmo_hit)          timeout <= 1'b1;
      else if (clr_timeout) timeout <= 1'b0;
    end
  end

`ifdef SND_SCHED_STATS_EN
  logic sent;
  assign sent = (state == WAIT_ACK) && !mb_full;

  always_ff @(posedge clk100) begin
    if (rst) begin
      stat_sent <= '0;
      stat_drop <= '0;
      stat_req1 <= '0;
    end else begin
      if (sent && (stat_sent != '1))       stat_sent <= stat_sent + 1'b1;
      if (tmo_hit && (stat_drop != '1))    stat_drop <= stat_drop + 1'b1;
      if (req1_ready && (stat_req1 != '1)) stat_req1 <= stat_req1 + 1'b1;
    end
  end
`endif

endmodule
